// File: rtl/lab_alu_seq.sv
// lab_alu_seq: small sequential ALU with a ready/valid handshake on both sides.
// AND/OR/ADD finish in one cycle; MUL runs an LSB-first shift-add over WIDTH
// cycles. Results wait in HOLD until the consumer takes them, and op_count
// counts the results that were taken.
module lab_alu_seq #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] f,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    localparam int FW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [FW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [FW-1:0]    f_q, f_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic          accept;
    logic          consume;
    logic          mul_last;
    logic [FW-1:0] acc_step;
    logic [FW-1:0] quick_res;

    assign accept   = in_valid && in_ready;
    assign consume  = (state_q == S_HOLD) && out_ready;
    assign mul_last = (bit_q == CW'(WIDTH - 1));
    // Partial product for the current multiplier bit folded into the accumulator.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign f        = f_q;
    assign op_count = op_count_q;

    // Single-cycle result for AND/OR/ADD; the ADD keeps its carry in bit WIDTH.
    always_comb begin
        quick_res = '0;
        case (op)
            2'b00:   quick_res = FW'(a & b);
            2'b01:   quick_res = FW'(a | b);
            default: quick_res = FW'({1'b0, a} + {1'b0, b});
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; HOLD can accept a new operation in the cycle it is consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = (op == 2'b11) ? S_MUL : S_HOLD;
            end
            S_MUL: begin
                if (mul_last) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (accept) begin
                    state_d = (op == 2'b11) ? S_MUL : S_HOLD;
                end else if (consume) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_MUL:   busy = 1'b1;
            S_HOLD: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath next values: operand capture, shift-add step, result and counter.
    always_comb begin
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        bit_d      = bit_q;
        f_d        = f_q;
        op_count_d = consume ? op_count_q + CNT_W'(1) : op_count_q;
        if (accept) begin
            if (op == 2'b11) begin
                mcand_d  = FW'(a);
                mplier_d = b;
                acc_d    = '0;
                bit_d    = '0;
            end else begin
                f_d = quick_res;
            end
        end else if (state_q == S_MUL) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            bit_d    = bit_q + CW'(1);
            if (mul_last) f_d = acc_step;
        end
    end

    // Datapath registers; reset clears the result, counter and multiply state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            bit_q      <= '0;
            f_q        <= '0;
            op_count_q <= '0;
        end else begin
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            bit_q      <= bit_d;
            f_q        <= f_d;
            op_count_q <= op_count_d;
        end
    end

endmodule

// File: tb/tb_lab_alu_seq.sv
// Testbench for lab_alu_seq: a WIDTH=2 instance for the table, sweep and
// handshake sequences, and a WIDTH=4 instance for the wide multiply case.
module tb_lab_alu_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=2 instance signals
    logic       iv2, ir2, ov2, or2, busy2;
    logic [1:0] a2, b2, op2;
    logic [3:0] f2;
    logic [7:0] cnt2;

    // WIDTH=4 instance signals
    logic       iv4, ir4, ov4, or4, busy4;
    logic [3:0] a4, b4;
    logic [1:0] op4;
    logic [7:0] f4;
    logic [7:0] cnt4;

    lab_alu_seq #(.WIDTH(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .op(op2), .out_valid(ov2), .out_ready(or2), .f(f2), .busy(busy2),
        .op_count(cnt2)
    );

    lab_alu_seq #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .op(op4), .out_valid(ov4), .out_ready(or4), .f(f4), .busy(busy4),
        .op_count(cnt4)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic [3:0] f;
        int         lat;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // One operation on the WIDTH=2 instance with out_ready held high.
    // Returns the result seen and the acceptance-to-out_valid latency in cycles.
    task automatic do_op2(input logic [1:0] ta, input logic [1:0] tb,
                          input logic [1:0] top, output logic [3:0] fg,
                          output int lat, output int nbusy);
        @(negedge clk);
        a2 = ta; b2 = tb; op2 = top; iv2 = 1'b1; or2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!ov2 && lat < 20) begin
            if (busy2) nbusy++;
            @(negedge clk);
            lat++;
        end
        fg = f2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] fg;
        int lat, nb, expf, k;

        tbl[0] = '{2'd3, 2'd2, 2'b00, 4'b0010, 1};
        tbl[1] = '{2'd3, 2'd2, 2'b01, 4'b0011, 1};
        tbl[2] = '{2'd3, 2'd2, 2'b10, 4'b0101, 1};
        tbl[3] = '{2'd3, 2'd3, 2'b11, 4'b1001, 3};
        tbl[4] = '{2'd0, 2'd0, 2'b10, 4'b0000, 1};
        tbl[5] = '{2'd3, 2'd3, 2'b10, 4'b0110, 1};
        tbl[6] = '{2'd2, 2'd3, 2'b11, 4'b0110, 3};
        tbl[7] = '{2'd1, 2'd2, 2'b00, 4'b0000, 1};
        tbl[8] = '{2'd1, 2'd2, 2'b01, 4'b0011, 1};

        rst = 1'b1;
        iv2 = 0; or2 = 0; a2 = 0; b2 = 0; op2 = 0;
        iv4 = 0; or4 = 0; a4 = 0; b4 = 0; op4 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset out_valid", ov2, 0);
        check("reset busy", busy2, 0);
        check("reset f", f2, 0);
        check("reset op_count", cnt2, 0);
        check("reset in_ready", ir2, 1);

        // Back-to-back AND, OR, ADD with 3 and 2.
        a2 = 2'd3; b2 = 2'd2; op2 = 2'b00; iv2 = 1'b1; or2 = 1'b1;
        @(negedge clk);
        check("b2b AND valid", ov2, 1);
        check("b2b AND f", f2, 4'b0010);
        check("b2b in_ready in HOLD", ir2, 1);
        op2 = 2'b01;
        @(negedge clk);
        check("b2b OR valid", ov2, 1);
        check("b2b OR f", f2, 4'b0011);
        op2 = 2'b10;
        @(negedge clk);
        check("b2b ADD valid", ov2, 1);
        check("b2b ADD f", f2, 4'b0101);
        iv2 = 1'b0;
        @(negedge clk);
        check("b2b idle out_valid", ov2, 0);
        check("b2b op_count", cnt2, 3);
        check("f held in IDLE", f2, 4'b0101);

        // Backpressure: result held for 4 cycles while new operands wait.
        a2 = 2'd1; b2 = 2'd2; op2 = 2'b10; iv2 = 1'b1; or2 = 1'b0;
        @(negedge clk);
        a2 = 2'd3; b2 = 2'd3; op2 = 2'b00;
        for (int i = 0; i < 4; i++) begin
            check("bp out_valid", ov2, 1);
            check("bp f", f2, 3);
            check("bp in_ready", ir2, 0);
            check("bp op_count", cnt2, 3);
            @(negedge clk);
        end
        iv2 = 1'b0; or2 = 1'b1;
        @(negedge clk);
        check("bp consumed out_valid", ov2, 0);
        check("bp consumed op_count", cnt2, 4);
        check("bp consumed f", f2, 3);

        // Reset during the second MUL cycle.
        a2 = 2'd3; b2 = 2'd3; op2 = 2'b11; iv2 = 1'b1; or2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        check("mul cycle1 busy", busy2, 1);
        check("mul cycle1 in_ready", ir2, 0);
        @(negedge clk);
        check("mul cycle2 busy", busy2, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midmul rst out_valid", ov2, 0);
        check("midmul rst busy", busy2, 0);
        check("midmul rst f", f2, 0);
        check("midmul rst op_count", cnt2, 0);
        check("midmul rst in_ready", ir2, 1);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            do_op2(tbl[i].a, tbl[i].b, tbl[i].op, fg, lat, nb);
            check($sformatf("tbl[%0d] f", i), fg, tbl[i].f);
            check($sformatf("tbl[%0d] latency", i), lat, tbl[i].lat);
            check($sformatf("tbl[%0d] busy cycles", i), nb, tbl[i].lat - 1);
        end

        // Exhaustive sweep against a reference model.
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int io = 0; io < 4; io++) begin
                    do_op2(2'(ia), 2'(ib), 2'(io), fg, lat, nb);
                    case (io)
                        0:       expf = ia & ib;
                        1:       expf = ia | ib;
                        2:       expf = ia + ib;
                        default: expf = ia * ib;
                    endcase
                    check($sformatf("sweep a=%0d b=%0d op=%0d f", ia, ib, io), fg, expf);
                    check($sformatf("sweep a=%0d b=%0d op=%0d lat", ia, ib, io), lat,
                          (io == 3) ? 3 : 1);
                end
            end
        end
        @(negedge clk);
        check("op_count after sweep", cnt2, 73);

        // Stream ADDs back-to-back until op_count wraps.
        a2 = 2'd1; b2 = 2'd1; op2 = 2'b10; iv2 = 1'b1; or2 = 1'b1;
        k = 183;
        repeat (k) @(negedge clk);
        check("stream op_count at max", cnt2, 255);
        check("stream f", f2, 2);
        iv2 = 1'b0;
        @(negedge clk);
        check("op_count wrap", cnt2, 0);
        check("stream drained out_valid", ov2, 0);

        // WIDTH=4: 15*15 with in_valid noise during MUL, then back-to-back ADD.
        a4 = 4'd15; b4 = 4'd15; op4 = 2'b11; iv4 = 1'b1; or4 = 1'b0;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1; op4 = 2'b00;
        check("w4 mul busy", busy4, 1);
        check("w4 mul in_ready", ir4, 0);
        repeat (3) @(negedge clk);
        check("w4 mul cycle4 out_valid", ov4, 0);
        check("w4 mul cycle4 busy", busy4, 1);
        @(negedge clk);
        check("w4 mul out_valid", ov4, 1);
        check("w4 mul busy done", busy4, 0);
        check("w4 mul f", f4, 8'hE1);
        a4 = 4'd15; b4 = 4'd15; op4 = 2'b10; or4 = 1'b1;
        @(negedge clk);
        check("w4 add out_valid", ov4, 1);
        check("w4 add f", f4, 8'h1E);
        check("w4 op_count after mul", cnt4, 1);
        iv4 = 1'b0;
        @(negedge clk);
        check("w4 idle out_valid", ov4, 0);
        check("w4 op_count", cnt4, 2);
        check("w4 f held", f4, 8'h1E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
